// File: rtl/vectorsum_host.sv
// vectorsum_host: streams (x, y) pairs into the core buffers, starts the core and streams the Z buffer back out
module vectorsum_host #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int VECTOR_SIZE = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    output logic                  x_wr_en,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic                  y_wr_en,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic                  start,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_z,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic [2:0] {S_LOAD, S_START, S_WAIT, S_READ, S_FETCH, S_OUT} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VECTOR_SIZE - 1);
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
    logic                  r_run;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_x_din, r_y_din;
    logic                  r_start, r_busy;
    logic [ADDR_WIDTH-1:0] r_z_rd_addr;
    logic                  r_out_valid, r_out_last;
    logic [DATA_WIDTH-1:0] r_out_z;
    logic                  w_in_hs, w_out_hs, w_is_last;
    // r_run keeps in_ready low until the first edge after reset release
    assign in_ready  = (r_state == S_LOAD) & r_run;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = r_out_valid & out_ready;
    assign w_is_last = (r_idx == LAST_IDX);
    assign x_wr_en   = r_wr_en;
    assign y_wr_en   = r_wr_en;
    assign x_wr_addr = r_wr_addr;
    assign y_wr_addr = r_wr_addr;
    assign x_din     = r_x_din;
    assign y_din     = r_y_din;
    assign start     = r_start;
    assign busy      = r_busy;
    assign z_rd_addr = r_z_rd_addr;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_z     = r_out_z;
    // next-state and shared element index for the load and read phases
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_LOAD: if (w_in_hs) begin
                w_idx_nxt   = w_is_last ? '0 : r_idx + 1'b1;
                w_state_nxt = w_is_last ? S_START : S_LOAD;
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = done ? S_READ : S_WAIT;
            S_READ:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_OUT;
            S_OUT: if (w_out_hs) begin
                w_idx_nxt   = r_out_last ? '0 : r_idx + 1'b1;
                w_state_nxt = r_out_last ? S_LOAD : S_READ;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end
    // state, index and post-reset run flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_run   <= 1'b1;
        end
    end
    // buffer writes follow each input handshake by one cycle; address and data hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_x_din   <= '0;
            r_y_din   <= '0;
        end else begin
            r_wr_en <= w_in_hs;
            if (w_in_hs) begin
                r_wr_addr <= r_idx;
                r_x_din   <= in_x;
                r_y_din   <= in_y;
            end
        end
    end
    // start pulses in the cycle after START, busy tracks every phase but loading
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= (r_state == S_START);
            r_busy  <= (w_state_nxt != S_LOAD);
        end
    end
    // read address is presented during READ and held until the next element is requested
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_z_rd_addr <= '0;
        else if (w_state_nxt == S_READ)
            r_z_rd_addr <= w_idx_nxt;
    end
    // result register: loaded in FETCH, held through OUT until accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_z     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (r_state == S_FETCH) begin
            r_out_z     <= z_dout;
            r_out_valid <= 1'b1;
            r_out_last  <= w_is_last;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vectorsum_host.sv
// tb_vectorsum_host: random and directed streams checked against a queue-based model with a behavioural core
module tb_vectorsum_host;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int N  = 64;
    logic          clock, reset;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_x, in_y;
    logic          x_wr_en, y_wr_en;
    logic [AW-1:0] x_wr_addr, y_wr_addr, z_rd_addr;
    logic [DW-1:0] x_din, y_din, z_dout, out_z;
    logic          start, done, out_valid, out_ready, out_last, busy;
    logic          core_done, early_done;
    int            total = 0;
    int            bad = 0;
    vectorsum_host #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_din(x_din),
        .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_din(y_din), .start(start), .done(done),
        .z_rd_addr(z_rd_addr), .z_dout(z_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_last(out_last), .busy(busy)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    assign done = core_done | early_done;
    // behavioural core: buffers, z = x + y, done about 10 cycles after start, 1-cycle read latency
    logic [DW-1:0] xm [1<<AW];
    logic [DW-1:0] ym [1<<AW];
    logic [DW-1:0] zm [1<<AW];
    int            dcnt;
    always @(posedge clock) begin
        if (x_wr_en) xm[x_wr_addr] <= x_din;
        if (y_wr_en) ym[y_wr_addr] <= y_din;
        z_dout    <= zm[z_rd_addr];
        core_done <= 1'b0;
        if (!reset) dcnt <= 0;
        else if (start) begin
            dcnt <= 10;
            for (int i = 0; i < N; i++) zm[i] <= xm[i] + ym[i];
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) core_done <= 1'b1;
        end
    end
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask
    // model state
    logic [2*DW-1:0] hs_q[$];
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   vx[N];
    logic [DW-1:0]   vy[N];
    logic [2*DW-1:0] p;
    logic [DW-1:0]   s;
    int  wr_cnt = 0, hs_n = 0, out_cnt = 0, vecs_done = 0, cyc = 0, last_hs = 0;
    bit  loading = 1, seen_edge = 0, start_due = 0, last_w = 0, ramp = 1, spacing_on = 0;
    // model update on posedge handshakes, full comparison on every negedge
    always @(posedge clock or negedge clock or negedge reset) begin
        if (!reset) begin
            hs_q.delete();
            exp_q.delete();
            wr_cnt = 0; hs_n = 0; out_cnt = 0;
            loading = 1; seen_edge = 0; start_due = 0;
            if (!clock) begin
                chk("rst_in_ready", 64'(in_ready), 0);
                chk("rst_x_wr_en", 64'(x_wr_en), 0);
                chk("rst_y_wr_en", 64'(y_wr_en), 0);
                chk("rst_x_wr_addr", 64'(x_wr_addr), 0);
                chk("rst_y_wr_addr", 64'(y_wr_addr), 0);
                chk("rst_x_din", 64'(x_din), 0);
                chk("rst_y_din", 64'(y_din), 0);
                chk("rst_start", 64'(start), 0);
                chk("rst_z_rd_addr", 64'(z_rd_addr), 0);
                chk("rst_out_valid", 64'(out_valid), 0);
                chk("rst_out_z", 64'(out_z), 0);
                chk("rst_out_last", 64'(out_last), 0);
                chk("rst_busy", 64'(busy), 0);
            end
        end else if (clock) begin
            cyc++;
            seen_edge = 1;
            if (in_valid && in_ready) begin
                hs_q.push_back({in_x, in_y});
                if (hs_n == N - 1) begin hs_n = 0; loading = 0; end
                else hs_n++;
            end
            if (out_valid && out_ready) begin
                if (spacing_on && out_cnt > 0) chk("spacing", 64'(cyc - last_hs), 3);
                last_hs = cyc;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (out_cnt == N - 1) begin out_cnt = 0; vecs_done++; loading = 1; end
                else out_cnt++;
            end
        end else begin
            chk("in_ready", 64'(in_ready), 64'(seen_edge && loading));
            chk("busy", 64'(busy), 64'(!loading));
            chk("x_wr_en", 64'(x_wr_en), 64'(hs_q.size() != 0));
            chk("y_wr_en", 64'(y_wr_en), 64'(hs_q.size() != 0));
            last_w = 0;
            if (hs_q.size() != 0) begin
                p = hs_q.pop_front();
                chk("x_wr_addr", 64'(x_wr_addr), 64'(wr_cnt));
                chk("y_wr_addr", 64'(y_wr_addr), 64'(wr_cnt));
                chk("x_din", 64'(x_din), 64'(p[2*DW-1:DW]));
                chk("y_din", 64'(y_din), 64'(p[DW-1:0]));
                vx[wr_cnt] = p[2*DW-1:DW];
                vy[wr_cnt] = p[DW-1:0];
                if (wr_cnt == N - 1) begin
                    for (int i = 0; i < N; i++) begin
                        s = vx[i] + vy[i];
                        exp_q.push_back(s);
                    end
                    wr_cnt = 0;
                    last_w = 1;
                end else wr_cnt++;
            end
            chk("start", 64'(start), 64'(start_due));
            start_due = last_w;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 0);
                else chk("out_z", 64'(out_z), 64'(exp_q[0]));
                chk("out_last", 64'(out_last), 64'(out_cnt == N - 1));
                chk("z_rd_addr_hold", 64'(z_rd_addr), 64'(out_cnt));
                if (ramp && out_cnt == 7) begin
                    chk("lit_z7", 64'(out_z), 21);
                    chk("lit_addr7", 64'(z_rd_addr), 7);
                end
                if (ramp && out_cnt == N - 1) chk("lit_z_last", 64'(out_z), 189);
            end else chk("out_last_idle", 64'(out_last), 0);
        end
    end
    // mode 0: in_valid held, 1: pattern 1,0,0 repeating, 2: random valid and data
    task automatic load_vec(input int mode);
        int n = 0, k = 0;
        while (n < N) begin
            in_valid = (mode == 1) ? (k % 3 == 0) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_x = (mode == 2) ? $urandom : n;
            in_y = (mode == 2) ? $urandom : 2 * n;
            @(negedge clock);
            if (in_valid && in_ready) n++;
            @(posedge clock);
            #1;
            k++;
            if (k > 2000) begin
                $display("FAIL load_timeout handshakes=%0d required=%0d", n, N);
                $fatal(1);
            end
        end
        in_valid = 1'b0;
    endtask
    // mode 0: out_ready held, 1: random with a 5-cycle stall at element 7, 2: random, stop at element 20
    task automatic drain(input int mode);
        int guard = 0, stall = 0, target;
        bit stalled = 0;
        target = vecs_done + 1;
        while (!(mode == 2 ? out_cnt == 20 : vecs_done == target)) begin
            if (mode == 0) out_ready = 1'b1;
            else if (stall > 0) begin out_ready = 1'b0; stall--; end
            else if (mode == 1 && !stalled && out_valid && out_cnt == 7) begin
                stalled = 1; stall = 4; out_ready = 1'b0;
            end else out_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            guard++;
            if (guard > 5000) begin
                $display("FAIL drain_timeout outputs=%0d required=%0d", out_cnt, N);
                $fatal(1);
            end
        end
    endtask
    initial begin
        reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
        out_ready = 1'b1; early_done = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        spacing_on = 1;
        load_vec(0);
        drain(0);
        load_vec(1);
        drain(0);
        @(posedge clock); #1 early_done = 1'b1;
        @(posedge clock); #1 early_done = 1'b0;
        load_vec(0);
        drain(0);
        spacing_on = 0;
        load_vec(0);
        drain(1);
        load_vec(0);
        drain(2);
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        ramp = 0;
        load_vec(2);
        drain(1);
        load_vec(2);
        drain(0);
        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
